// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: widths, fetch FSM states and the decode bubble word.
package rv32i_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready holding register between fetch and decode.
module fetch_out_buf
    import rv32i_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;

    // Flush wins over load so a word racing a redirect never reaches decode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requester, next-PC generation and
// redirect flush, feeding decode through a one-entry output buffer.
module fetch_unit
    import rv32i_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [XLEN-1:0] PC_Cur,
    output logic [XLEN-1:0] PC_Next,
    input  logic            Redirect,
    input  logic [XLEN-1:0] Redirect_PC,
    output logic            Imem_Req,
    output logic [XLEN-1:0] Imem_Addr,
    input  logic            Imem_Ready,
    input  logic            Imem_Rvalid,
    input  logic [31:0]     Imem_Rdata,
    output logic            Dec_Valid,
    output logic [31:0]     Dec_Instr,
    output logic [XLEN-1:0] Dec_PC,
    input  logic            Dec_Ready
);

    localparam logic [XLEN-1:0] AlignMask = ~XLEN'(32'd3);

    fetch_state_t    r_state;
    fetch_state_t    w_state_d;
    logic [XLEN-1:0] r_req_pc;
    logic            w_buf_free;
    logic            w_accept;
    logic            w_load;

    assign w_buf_free = !Dec_Valid || Dec_Ready;
    assign Imem_Req   = (r_state == REQ) && w_buf_free && !Redirect;
    assign Imem_Addr  = PC_Cur & AlignMask;
    assign w_accept   = Imem_Req && Imem_Ready;
    assign w_load     = (r_state == WAIT) && Imem_Rvalid && !Redirect;

    always_comb begin
        PC_Next = PC_Cur;
        if (Redirect) begin
            PC_Next = Redirect_PC & AlignMask;
        end else if (w_accept) begin
            PC_Next = PC_Cur + XLEN'(INSTR_BYTES);
        end
    end

    // A redirect never forces a transition by itself; it only suppresses the accept
    // in REQ, the buffer load in WAIT, and turns a response-less WAIT into DROP.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: w_state_d = REQ;
            REQ:  if (w_accept) w_state_d = WAIT;
            WAIT: begin
                if (Imem_Rvalid) begin
                    w_state_d = REQ;
                end else if (Redirect) begin
                    w_state_d = DROP;
                end
            end
            DROP: if (Imem_Rvalid) w_state_d = REQ;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_req_pc <= PC_Cur;
            end
        end
    end

    fetch_out_buf u_out_buf (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_flush (Redirect),
        .i_load  (w_load),
        .i_instr (Imem_Rdata),
        .i_pc    (r_req_pc),
        .i_ready (Dec_Ready),
        .o_valid (Dec_Valid),
        .o_instr (Dec_Instr),
        .o_pc    (Dec_PC)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of `Program_Counter`. It consumes the current PC and issues one instruction-memory request at a time over a valid/ready handshake. It returns each fetched word with its PC to decode through a one-entry output buffer. It computes the next PC, which drives `PC_In`, so the PC register advances only when a fetch is accepted, and it flushes in-flight work on a redirect.

## Interface
- `XLEN`, 32: datapath and address width.
- `INSTR_BYTES`, 4: PC increment per fetched instruction.
- `Clk` in 1: clock; all state updates on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset. The top level drives `Program_Counter`'s `Reset` from `~Reset_n`.
- `PC_Cur` in XLEN: current PC, from `PC_Out`.
- `PC_Next` out XLEN: next PC, to `PC_In`; combinational.
- `Redirect` in 1: flush plus new fetch target (branch, jump, trap).
- `Redirect_PC` in XLEN: redirect target.
- `Imem_Req` out 1: request valid.
- `Imem_Addr` out XLEN: request address; always `PC_Cur` with bits [1:0] forced to 0.
- `Imem_Ready` in 1: memory accepts the request.
- `Imem_Rvalid` in 1: response valid; no back-pressure.
- `Imem_Rdata` in 32: response instruction word.
- `Dec_Valid` out 1: instruction available to decode.
- `Dec_Instr` out 32: fetched instruction.
- `Dec_PC` out XLEN: PC of `Dec_Instr`.
- `Dec_Ready` in 1: decode accepts.

## Operation
- FSM states: IDLE, REQ, WAIT, DROP.
- **Reset values.** State = IDLE. `Dec_Valid`, `Dec_Instr`, `Dec_PC` and the internal `Req_PC` are all 0. `Imem_Req` = 0.
- **IDLE.** Unconditionally moves to REQ on the next edge.
- **REQ.**
  - `Imem_Req` = 1 only when the output buffer is free: `!Dec_Valid || Dec_Ready`. Otherwise `Imem_Req` = 0.
  - Accept is `Imem_Req && Imem_Ready`. On accept: `PC_Next` = `PC_Cur` + `INSTR_BYTES`, modulo 2^XLEN, so 32'hFFFFFFFC wraps to 0. `Req_PC` latches `PC_Cur`. State moves to WAIT.
  - Without accept, `PC_Next` = `PC_Cur`.
- **WAIT.**
  - On `Imem_Rvalid`: the buffer loads `Dec_Instr` = `Imem_Rdata` and `Dec_PC` = `Req_PC`, `Dec_Valid` is set, and state moves to REQ.
  - The issue rule guarantees the buffer is empty at response time.
- **DROP.** The next `Imem_Rvalid` is discarded, then state moves to REQ.
- **Output buffer.** While `Dec_Valid && !Dec_Ready`, `Dec_Valid`, `Dec_Instr` and `Dec_PC` hold stable. A drain (`Dec_Ready`) and a new issue in the same cycle are legal.
- **Redirect (highest priority, any state):**
  - `PC_Next` = `Redirect_PC` with bits [1:0] forced to 0.
  - `Imem_Req` is forced to 0 that cycle, so no accept occurs.
  - `Dec_Valid` clears on the next edge.
  - From WAIT without `Imem_Rvalid`: go to DROP.
  - From WAIT with `Imem_Rvalid` in the same cycle: drop that word and go to REQ.
  - From DROP: stay in DROP.
  - From IDLE or REQ: go to REQ.
- **Handshake rule.** Once `Imem_Req` is asserted, it stays asserted with `Imem_Addr` stable until `Imem_Ready`. The only exception is a redirect, which aborts the request; memory must tolerate the withdrawal.
- At most one outstanding request at any time.

## Timing
- Request accepted in cycle N. `Imem_Rvalid` may arrive no earlier than N+1; a same-cycle response is illegal.
- `Imem_Rvalid` in cycle M gives `Dec_Valid` = 1 from M+1.
- The next request can issue in M+1. With 1-cycle memory, throughput is one instruction every 2 cycles when decode is always ready.
- The PC register updates on the edge ending the accept cycle, so `PC_Cur` shows the incremented value from N+1.
- A redirect in cycle R puts the target in `PC_Cur` and the first request on the bus at R+1. The earliest `Dec_Valid` for the target is R+3.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). Any response arriving after reset release while in IDLE or REQ is ignored.

## Structure
- Shared package `rv32i_pkg`:
  - `XLEN`
  - `INSTR_BYTES`
  - fetch state enum `fetch_state_t` {IDLE, REQ, WAIT, DROP}
  - `NOP_INSTR` = 32'h00000013, for decode-side bubbles
- One sub-module, `fetch_out_buf`: a one-entry valid/ready register holding Instr and PC, with a flush input. The FSM and next-PC logic stay in `fetch_unit`.

## Test plan
- Reset release, 1-cycle memory, `Dec_Ready` = 1 → requests at 0x0, 0x4, 0x8 every 2 cycles. Each `Dec_PC` matches its request and `Dec_Instr` equals the memory word.
- `Imem_Ready` held low 3 cycles with `PC_Cur` = 0x10 → `Imem_Req` and `Imem_Addr` stable, `PC_Next` = 0x10, then exactly one accept, and `PC_Next` = 0x14 in the accept cycle.
- `Dec_Ready` = 0 with buffer full at 0x20 → no new request issued. Output stays 0x20 stable until `Dec_Ready` rises; the request for 0x24 issues that same cycle.
- Redirect to 0x100 while in WAIT, with the stale response arriving 2 cycles later → stale word never reaches decode, and the next `Dec_PC` is 0x100.
- `PC_Cur` = 32'hFFFFFFFC accepted → `PC_Next` = 0. Redirect to 0x103 → `Imem_Addr` = 0x100.
- `Reset_n` asserted while in WAIT → outputs 0 immediately. After release, the first request goes to the PC's reset value, and the late response is ignored.
